map_read_arbiter: RTL and testbench

// - Shares the single read port of the N x N grid-map BRAM between two requesters: the DDA raycaster
//   (primary) and the player-movement collision checker (secondary).
// - Converts (x,y) grid coords to a linear address, tracks in-flight reads, routes each result to its owner.
// - Sits between the map BRAM and its requesters; fixed-latency, in-order, no response backpressure.

---
 rtl/map_read_arbiter_pkg.sv | 26 ++
 rtl/map_read_arbiter_if.sv | 42 ++++
 rtl/map_read_arbiter_tag_pipe.sv | 28 ++
 rtl/map_read_arbiter.sv | 98 +++++++++
 tb/tb_map_read_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/map_read_arbiter_pkg.sv
// Shared constants and types for the grid-map read arbiter: map geometry and read-tag layout.
package map_read_arbiter_pkg;

    localparam int unsigned N          = 24;
    localparam int unsigned COORD_W    = 8;
    localparam int unsigned DATA_W     = 4;
    localparam int unsigned MAP_ADDR_W = $clog2(N * N);

    localparam logic [DATA_W-1:0] OOB_VALUE = DATA_W'(1);

    typedef logic [COORD_W-1:0]    coord_t;
    typedef logic [DATA_W-1:0]     cell_t;
    typedef logic [MAP_ADDR_W-1:0] map_addr_t;

    typedef enum logic {
        OWN_DDA,
        OWN_COL
    } owner_t;

    typedef struct packed {
        logic   vld;
        owner_t own;
        logic   oob;
    } rd_tag_t;

endpackage

// File: rtl/map_read_arbiter_if.sv
// Request/response bundle between the two map requesters, the arbiter and the map BRAM.
interface map_read_arbiter_if;
    import map_read_arbiter_pkg::*;

    logic      dda_req_valid;
    coord_t    dda_req_x;
    coord_t    dda_req_y;
    logic      dda_req_ready;
    logic      dda_rsp_valid;
    cell_t     dda_rsp_data;

    logic      col_req_valid;
    coord_t    col_req_x;
    coord_t    col_req_y;
    logic      col_req_ready;
    logic      col_rsp_valid;
    cell_t     col_rsp_data;

    map_addr_t map_addr_out;
    cell_t     map_data_in;

    // Arbiter side.
    modport slave (
        input  dda_req_valid, dda_req_x, dda_req_y,
        output dda_req_ready, dda_rsp_valid, dda_rsp_data,
        input  col_req_valid, col_req_x, col_req_y,
        output col_req_ready, col_rsp_valid, col_rsp_data,
        output map_addr_out,
        input  map_data_in
    );

    // Requesters plus BRAM side.
    modport master (
        output dda_req_valid, dda_req_x, dda_req_y,
        input  dda_req_ready, dda_rsp_valid, dda_rsp_data,
        output col_req_valid, col_req_x, col_req_y,
        input  col_req_ready, col_rsp_valid, col_rsp_data,
        input  map_addr_out,
        output map_data_in
    );

endinterface

// File: rtl/map_read_arbiter_tag_pipe.sv
// Fixed-depth shift register of read tags that tracks in-flight BRAM reads alongside the data path.
module map_read_arbiter_tag_pipe
    import map_read_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t [Depth-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int unsigned i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/map_read_arbiter.sv
// Shares the map BRAM read port between the DDA raycaster (priority) and the collision checker,
// with a starvation bound for the collision side and in-order, fixed-latency response routing.
module map_read_arbiter
    import map_read_arbiter_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               pixel_clk_in,
    input logic               rst_n_in,
    map_read_arbiter_if.slave bus
);

    localparam int unsigned ADDR_FULL_W = 2 * COORD_W + 1;
    localparam int unsigned STARVE_W    = $clog2(STARVE_LIMIT + 1);

    localparam coord_t               N_COORD    = COORD_W'(N);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q, starve_d;
    map_addr_t           map_addr_q, map_addr_d;
    cell_t               dda_data_q, dda_data_d;
    cell_t               col_data_q, col_data_d;

    logic      col_prio, dda_gnt, col_gnt;
    coord_t    sel_x, sel_y;
    logic      sel_oob;
    map_addr_t sel_addr;
    rd_tag_t   req_tag, rsp_tag;
    cell_t     rsp_val;

    // Collision only beats DDA once it has been passed over STARVE_LIMIT times in a row.
    assign col_prio = bus.col_req_valid && (starve_q == STARVE_MAX);
    assign dda_gnt  = bus.dda_req_valid && !col_prio;
    assign col_gnt  = bus.col_req_valid && (col_prio || !bus.dda_req_valid);

    assign bus.dda_req_ready = dda_gnt;
    assign bus.col_req_ready = col_gnt;

    assign sel_x    = col_gnt ? bus.col_req_x : bus.dda_req_x;
    assign sel_y    = col_gnt ? bus.col_req_y : bus.dda_req_y;
    assign sel_oob  = (sel_x >= N_COORD) || (sel_y >= N_COORD);
    assign sel_addr = MAP_ADDR_W'(ADDR_FULL_W'(sel_y) * ADDR_FULL_W'(N) + ADDR_FULL_W'(sel_x));

    always_comb begin
        starve_d = starve_q;
        if (!bus.col_req_valid || col_gnt) begin
            starve_d = '0;
        end else if (dda_gnt && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_comb begin
        req_tag     = '0;
        req_tag.vld = dda_gnt || col_gnt;
        req_tag.own = col_gnt ? OWN_COL : OWN_DDA;
        req_tag.oob = sel_oob;
    end

    // Out-of-range reads leave the BRAM address alone; their data is substituted on return.
    assign map_addr_d       = (req_tag.vld && !sel_oob) ? sel_addr : map_addr_q;
    assign bus.map_addr_out = map_addr_d;

    map_read_arbiter_tag_pipe #(
        .Depth (READ_LATENCY)
    ) u_tag_pipe (
        .clk_i  (pixel_clk_in),
        .rst_ni (rst_n_in),
        .tag_i  (req_tag),
        .tag_o  (rsp_tag)
    );

    assign rsp_val           = rsp_tag.oob ? OOB_VALUE : bus.map_data_in;
    assign bus.dda_rsp_valid = rsp_tag.vld && (rsp_tag.own == OWN_DDA);
    assign bus.col_rsp_valid = rsp_tag.vld && (rsp_tag.own == OWN_COL);

    assign dda_data_d = bus.dda_rsp_valid ? rsp_val : dda_data_q;
    assign col_data_d = bus.col_rsp_valid ? rsp_val : col_data_q;

    assign bus.dda_rsp_data = dda_data_d;
    assign bus.col_rsp_data = col_data_d;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            starve_q   <= '0;
            map_addr_q <= '0;
            dda_data_q <= '0;
            col_data_q <= '0;
        end else begin
            starve_q   <= starve_d;
            map_addr_q <= map_addr_d;
            dda_data_q <= dda_data_d;
            col_data_q <= col_data_d;
        end
    end

endmodule

// File: tb/tb_map_read_arbiter.sv
// Directed bench for map_read_arbiter with a two-stage registered BRAM model.
module tb_map_read_arbiter;
    import map_read_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    map_read_arbiter_if bus ();

    map_read_arbiter #(
        .READ_LATENCY (2),
        .STARVE_LIMIT (4)
    ) dut (
        .pixel_clk_in (clk),
        .rst_n_in     (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Map contents: cell(a) = (a + 15) mod 16, so cell 51 = 2.
    function automatic cell_t model_cell(input map_addr_t a);
        map_addr_t s;
        s = a + MAP_ADDR_W'(15);
        return s[DATA_W-1:0];
    endfunction

    map_addr_t bram_addr_q;
    cell_t     bram_data_q;
    always @(posedge clk) begin
        bram_addr_q <= bus.map_addr_out;
        bram_data_q <= model_cell(bram_addr_q);
    end
    assign bus.map_data_in = bram_data_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_dda(input logic v, input int x, input int y);
        bus.dda_req_valid = v;
        bus.dda_req_x     = COORD_W'(x);
        bus.dda_req_y     = COORD_W'(y);
    endtask

    task automatic drive_col(input logic v, input int x, input int y);
        bus.col_req_valid = v;
        bus.col_req_x     = COORD_W'(x);
        bus.col_req_y     = COORD_W'(y);
    endtask

    // Arbitration stream with both requesters always valid: every fifth grant goes to collision.
    function automatic logic col_turn(input int c);
        return (c % 5) == 4;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic saw;
        logic col_v_tbl [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic col_g_tbl [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        drive_dda(1'b0, 0, 0);
        drive_col(1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check_eq("rst_dda_ready", bus.dda_req_ready, 0);
        check_eq("rst_col_ready", bus.col_req_ready, 0);
        check_eq("rst_addr", bus.map_addr_out, 0);
        check_eq("rst_dda_data", bus.dda_rsp_data, 0);

        // Two reads in flight, then reset: neither may respond.
        next_cycle();
        drive_dda(1'b1, 1, 0);
        @(negedge clk);
        check_eq("inflight_ready", bus.dda_req_ready, 1);
        next_cycle();
        drive_dda(1'b1, 2, 0);
        next_cycle();
        drive_dda(1'b0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.dda_rsp_valid || bus.col_rsp_valid) saw = 1'b1;
            if (i < 3) next_cycle();
        end
        check_eq("rst_no_rsp", saw, 0);
        check_eq("rst_addr_after", bus.map_addr_out, 0);
        check_eq("rst_data_after", bus.dda_rsp_data, 0);

        // Single DDA read at (3,2) -> address 51.
        next_cycle();
        drive_dda(1'b1, 3, 2);
        @(negedge clk);
        check_eq("single_ready", bus.dda_req_ready, 1);
        check_eq("single_addr", bus.map_addr_out, 51);
        next_cycle();
        drive_dda(1'b0, 0, 0);
        @(negedge clk);
        check_eq("single_early", bus.dda_rsp_valid, 0);
        next_cycle();
        @(negedge clk);
        check_eq("single_valid", bus.dda_rsp_valid, 1);
        check_eq("single_data", bus.dda_rsp_data, 2);
        check_eq("single_col_quiet", bus.col_rsp_valid, 0);
        next_cycle();
        @(negedge clk);
        check_eq("single_pulse", bus.dda_rsp_valid, 0);
        check_eq("single_hold", bus.dda_rsp_data, 2);

        // Both valid: DDA at (0,1)=24 -> 7, collision at (5,1)=29 -> 12.
        for (int c = 0; c < 17; c++) begin
            next_cycle();
            if (c == 0) begin
                drive_dda(1'b1, 0, 1);
                drive_col(1'b1, 5, 1);
            end else if (c == 15) begin
                drive_dda(1'b0, 0, 0);
                drive_col(1'b0, 0, 0);
            end
            @(negedge clk);
            if (c < 15) begin
                check_eq($sformatf("arb_dda_rdy%0d", c), bus.dda_req_ready, !col_turn(c));
                check_eq($sformatf("arb_col_rdy%0d", c), bus.col_req_ready, col_turn(c));
                check_eq($sformatf("arb_addr%0d", c), bus.map_addr_out, col_turn(c) ? 29 : 24);
            end
            if (c >= 2) begin
                check_eq($sformatf("arb_dda_rsp%0d", c), bus.dda_rsp_valid, !col_turn(c - 2));
                check_eq($sformatf("arb_col_rsp%0d", c), bus.col_rsp_valid, col_turn(c - 2));
                if (col_turn(c - 2)) check_eq($sformatf("arb_col_data%0d", c), bus.col_rsp_data, 12);
                else check_eq($sformatf("arb_dda_data%0d", c), bus.dda_rsp_data, 7);
            end
        end

        // Collision drops its request for a cycle: the starve count restarts from zero.
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            if (c < 8) begin
                drive_dda(1'b1, 0, 1);
                drive_col(col_v_tbl[c], 5, 1);
            end else begin
                drive_dda(1'b0, 0, 0);
                drive_col(1'b0, 0, 0);
            end
            @(negedge clk);
            if (c < 8) begin
                check_eq($sformatf("starve_col_rdy%0d", c), bus.col_req_ready, col_g_tbl[c]);
                check_eq($sformatf("starve_dda_rdy%0d", c), bus.dda_req_ready, !col_g_tbl[c]);
            end
            if (c == 9) begin
                check_eq("starve_col_rsp", bus.col_rsp_valid, 1);
                check_eq("starve_col_data", bus.col_rsp_data, 12);
            end
        end

        // Out-of-range collision read (24,0): address holds at 29, data is the wall value.
        next_cycle();
        drive_col(1'b1, 24, 0);
        @(negedge clk);
        check_eq("oob_ready", bus.col_req_ready, 1);
        check_eq("oob_addr_hold", bus.map_addr_out, 29);
        next_cycle();
        drive_col(1'b0, 0, 0);
        @(negedge clk);
        check_eq("oob_early", bus.col_rsp_valid, 0);
        next_cycle();
        @(negedge clk);
        check_eq("oob_valid", bus.col_rsp_valid, 1);
        check_eq("oob_data", bus.col_rsp_data, OOB_VALUE);
        check_eq("oob_dda_quiet", bus.dda_rsp_valid, 0);
        check_eq("oob_addr_after", bus.map_addr_out, 29);

        // Corner cell (23,23)=575 then y out of range, back to back.
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            if (c == 0) drive_dda(1'b1, 23, 23);
            else if (c == 1) drive_dda(1'b1, 0, 24);
            else drive_dda(1'b0, 0, 0);
            @(negedge clk);
            if (c < 2) check_eq($sformatf("edge_addr%0d", c), bus.map_addr_out, 575);
            if (c >= 2) begin
                check_eq($sformatf("edge_valid%0d", c), bus.dda_rsp_valid, 1);
                check_eq($sformatf("edge_data%0d", c), bus.dda_rsp_data, (c == 2) ? 14 : 1);
            end
        end

        // Ten back-to-back DDA reads of addresses 0..9.
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            if (c < 10) drive_dda(1'b1, c, 0);
            else drive_dda(1'b0, 0, 0);
            @(negedge clk);
            if (c < 10) begin
                check_eq($sformatf("b2b_ready%0d", c), bus.dda_req_ready, 1);
                check_eq($sformatf("b2b_addr%0d", c), bus.map_addr_out, c);
            end
            if (c >= 2) begin
                check_eq($sformatf("b2b_valid%0d", c), bus.dda_rsp_valid, 1);
                check_eq($sformatf("b2b_data%0d", c), bus.dda_rsp_data, (c - 2 + 15) % 16);
                check_eq($sformatf("b2b_col%0d", c), bus.col_rsp_valid, 0);
            end
        end
        next_cycle();
        @(negedge clk);
        check_eq("b2b_done", bus.dda_rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
